gate_vector_checker: RTL and testbench

Self-checking response end of the basic-gate stimulus flow: accepts (A,B) test vectors over a valid/ready handshake and drives them, held stable, into a 2-input gate under test. After a fixed settle time it samples the gate output Q, compares it against an expected 4-entry truth table and keeps pass/fail counts. It sits beside any 2-input gate in the basic-gate library, and lets a bench or an on-board harness report a verdict instead of relying on waveform inspection.

---
 rtl/gate_chk_pkg.sv | 23 ++
 rtl/sat_counter.sv | 25 ++
 rtl/gate_vector_checker.sv | 140 ++++++++++++++
 tb/tb_gate_vector_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StWait,
        StCheck,
        StDone
    } state_e;

    // Expected-Q tables, indexed by {A,B}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    function automatic logic tt_lookup(input logic [3:0] tt, input logic a, input logic b);
        return tt[{a, b}];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: reset/clear to zero, increment unless saturated
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/gate_vector_checker.sv
// Drives (A,B) vectors into a 2-input gate, waits LATENCY cycles, then
// checks Q against a latched truth table and counts passes/fails.
// Optional macro GATE_CHK_FIRST_FAIL_EN adds capture of the first failing vector.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_truth,
    input  logic             i_vec_valid,
    output logic             o_vec_ready,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_last,
    output logic             o_dut_a,
    output logic             o_dut_b,
    input  logic             i_q,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic [1:0]       o_first_fail_vec,
    output logic             o_first_fail_valid
`endif
);

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_settle;
    logic [3:0] r_truth;
    logic       r_last;
    logic       r_dut_a;
    logic       r_dut_b;

    logic w_accept;
    logic w_clear;
    logic w_check;
    logic w_match;
    logic w_pass_inc;
    logic w_fail_inc;

    assign w_accept   = (r_state == StAccept) && i_vec_valid;
    assign w_clear    = i_start && ((r_state == StIdle) || (r_state == StDone));
    assign w_check    = (r_state == StCheck);
    assign w_match    = (i_q == tt_lookup(r_truth, r_dut_a, r_dut_b));
    assign w_pass_inc = w_check && w_match;
    assign w_fail_inc = w_check && !w_match;

    // Next-state logic for the session FSM
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_next = StAccept;
            StAccept: if (i_vec_valid) w_state_next = StWait;
            StWait:   if (r_settle == 4'd0) w_state_next = StCheck;
            StCheck:  w_state_next = r_last ? StDone : StAccept;
            StDone:   if (i_start) w_state_next = StAccept;
            default:  w_state_next = StIdle;
        endcase
    end

    // State, truth latch, vector drive and settle countdown
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_settle <= 4'd0;
            r_truth  <= 4'd0;
            r_last   <= 1'b0;
            r_dut_a  <= 1'b0;
            r_dut_b  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_clear) begin
                r_truth <= i_truth;
            end
            if (w_accept) begin
                r_dut_a  <= i_a;
                r_dut_b  <= i_b;
                r_last   <= i_last;
                r_settle <= 4'(LATENCY);
            end else if ((r_state == StWait) && (r_settle != 4'd0)) begin
                r_settle <= r_settle - 4'd1;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_pass_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_clear),
        .i_inc (w_pass_inc),
        .o_cnt (o_pass_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_fail_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_clear),
        .i_inc (w_fail_inc),
        .o_cnt (o_fail_cnt)
    );

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] r_ff_vec;
    logic       r_ff_valid;

    // Capture {A,B} of the first mismatch; held until the next start or reset
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clear) begin
            r_ff_vec   <= 2'b00;
            r_ff_valid <= 1'b0;
        end else if (w_fail_inc && !r_ff_valid) begin
            r_ff_vec   <= {r_dut_a, r_dut_b};
            r_ff_valid <= 1'b1;
        end
    end

    assign o_first_fail_vec   = r_ff_vec;
    assign o_first_fail_valid = r_ff_valid;
`endif

    assign o_vec_ready = (r_state == StAccept);
    assign o_busy      = (r_state == StAccept) || (r_state == StWait) || (r_state == StCheck);
    assign o_done      = (r_state == StDone);
    assign o_error     = o_done && (o_fail_cnt != '0);
    assign o_dut_a     = r_dut_a;
    assign o_dut_b     = r_dut_b;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: three checker instances (LATENCY=1, LATENCY=0, CNT_W=2),
// each facing a behavioural NOR gate.
module tb_gate_vector_checker;
    import gate_chk_pkg::*;

    logic       clk;
    logic [2:0] rst, start, vv, ia, ib, il;
    logic [3:0] truth;
    logic [2:0] rdy, da, db, busy, done, err;
    logic [2:0] q;
    logic [7:0] pc0, fc0, pc1, fc1;
    logic [1:0] pc2, fc2;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] ffv0, ffv1, ffv2;
    logic [2:0] ffval;
`endif

    int total = 0;
    int bad   = 0;
    time t0, t1, t2, t3;

    // Gate under test: NOR for every instance
    assign q = ~(da | db);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gate_vector_checker #(.LATENCY(1), .CNT_W(8)) u0 (
        .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_truth(truth),
        .i_vec_valid(vv[0]), .o_vec_ready(rdy[0]), .i_a(ia[0]), .i_b(ib[0]),
        .i_last(il[0]), .o_dut_a(da[0]), .o_dut_b(db[0]), .i_q(q[0]),
        .o_pass_cnt(pc0), .o_fail_cnt(fc0), .o_busy(busy[0]), .o_done(done[0]),
        .o_error(err[0])
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .o_first_fail_vec(ffv0), .o_first_fail_valid(ffval[0])
`endif
    );

    gate_vector_checker #(.LATENCY(0), .CNT_W(8)) u1 (
        .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_truth(truth),
        .i_vec_valid(vv[1]), .o_vec_ready(rdy[1]), .i_a(ia[1]), .i_b(ib[1]),
        .i_last(il[1]), .o_dut_a(da[1]), .o_dut_b(db[1]), .i_q(q[1]),
        .o_pass_cnt(pc1), .o_fail_cnt(fc1), .o_busy(busy[1]), .o_done(done[1]),
        .o_error(err[1])
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .o_first_fail_vec(ffv1), .o_first_fail_valid(ffval[1])
`endif
    );

    gate_vector_checker #(.LATENCY(1), .CNT_W(2)) u2 (
        .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .i_truth(truth),
        .i_vec_valid(vv[2]), .o_vec_ready(rdy[2]), .i_a(ia[2]), .i_b(ib[2]),
        .i_last(il[2]), .o_dut_a(da[2]), .o_dut_b(db[2]), .i_q(q[2]),
        .o_pass_cnt(pc2), .o_fail_cnt(fc2), .o_busy(busy[2]), .o_done(done[2]),
        .o_error(err[2])
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .o_first_fail_vec(ffv2), .o_first_fail_valid(ffval[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k, input logic [3:0] tt);
        truth    = tt;
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    // Offer a vector and hold it until accepted; returns the accepting edge time
    task automatic send_vec(input int k, input bit a, input bit b, input bit l,
                            output time t_acc);
        bit got;
        got   = 1'b0;
        t_acc = 0;
        vv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        il[k] = l;
        for (int n = 0; n < 40 && !got; n++) begin
            if (rdy[k]) got = 1'b1;
            @(posedge clk);
            t_acc = $time;
            #1;
        end
        vv[k] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $error("FAIL accept_timeout: instance %0d observed=no_accept expected=accept", k);
        end
    endtask

    initial begin
        rst = 3'b111; start = '0; vv = '0; ia = '0; ib = '0; il = '0; truth = 4'd0;
        tick();
        tick();
        // Reset state
        chk("rst_ready", rdy[0], 0);
        chk("rst_busy",  busy[0], 0);
        chk("rst_done",  done[0], 0);
        chk("rst_error", err[0], 0);
        chk("rst_pass",  pc0, 0);
        chk("rst_fail",  fc0, 0);
        chk("rst_dut",   {da[0], db[0]}, 0);
        rst = 3'b000;
        // vec_valid in IDLE is not consumed
        vv[0] = 1'b1; ia[0] = 1'b1; ib[0] = 1'b1;
        tick();
        tick();
        vv[0] = 1'b0;
        chk("idle_no_accept_dut",  {da[0], db[0]}, 0);
        chk("idle_no_accept_busy", busy[0], 0);

        // NOR truth against NOR gate, LATENCY=1
        pulse_start(0, TT_NOR);
        chk("accept_ready", rdy[0], 1);
        chk("accept_busy",  busy[0], 1);
        send_vec(0, 1'b0, 1'b0, 1'b0, t0);
        chk("wait_ready_low", rdy[0], 0);
        tick();
        tick();
        chk("pass_before_check_end", pc0, 0);
        tick();
        chk("pass_after_check", pc0, 1);
        send_vec(0, 1'b0, 1'b1, 1'b0, t1);
        send_vec(0, 1'b1, 1'b0, 1'b0, t2);
        send_vec(0, 1'b1, 1'b1, 1'b1, t3);
        chk("l1_spacing_a", 32'((t1 - t0) / 10), 4);
        chk("l1_spacing_b", 32'((t3 - t2) / 10), 4);
        chk("dut_drive_11", {da[0], db[0]}, 2'b11);
        tick();
        tick();
        chk("done_not_yet", done[0], 0);
        tick();
        chk("nor_done",  done[0], 1);
        chk("nor_pass",  pc0, 4);
        chk("nor_fail",  fc0, 0);
        chk("nor_error", err[0], 0);
        chk("nor_busy",  busy[0], 0);

        // OR truth against NOR gate: every vector fails
        pulse_start(0, TT_OR);
        chk("restart_clear_pass", pc0, 0);
        chk("restart_done_low",   done[0], 0);
        send_vec(0, 1'b0, 1'b0, 1'b0, t0);
        send_vec(0, 1'b0, 1'b1, 1'b0, t0);
        send_vec(0, 1'b1, 1'b0, 1'b0, t0);
        send_vec(0, 1'b1, 1'b1, 1'b1, t0);
        tick();
        tick();
        tick();
        chk("or_pass",  pc0, 0);
        chk("or_fail",  fc0, 4);
        chk("or_error", err[0], 1);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("ff_vec",   ffv0, 2'b00);
        chk("ff_valid", ffval[0], 1);
`endif
        tick();
        tick();
        chk("done_frozen_fail", fc0, 4);

        // LATENCY=0, back-to-back vectors
        pulse_start(1, TT_NOR);
        send_vec(1, 1'b0, 1'b0, 1'b0, t0);
        chk("l0_wait_ready", rdy[1], 0);
        tick();
        chk("l0_check_ready", rdy[1], 0);
        tick();
        chk("l0_accept_ready", rdy[1], 1);
        send_vec(1, 1'b1, 1'b0, 1'b0, t1);
        send_vec(1, 1'b0, 1'b1, 1'b1, t2);
        chk("l0_spacing_a", 32'((t1 - t0) / 10), 3);
        chk("l0_spacing_b", 32'((t2 - t1) / 10), 3);
        tick();
        tick();
        chk("l0_done", done[1], 1);
        chk("l0_pass", pc1, 3);

        // CNT_W=2 saturation
        pulse_start(2, TT_NOR);
        send_vec(2, 1'b0, 1'b0, 1'b0, t0);
        send_vec(2, 1'b0, 1'b1, 1'b0, t0);
        send_vec(2, 1'b1, 1'b0, 1'b0, t0);
        tick();
        tick();
        tick();
        chk("sat_reach", pc2, 3);
        send_vec(2, 1'b1, 1'b1, 1'b0, t0);
        tick();
        tick();
        tick();
        chk("sat_hold", pc2, 3);
        send_vec(2, 1'b0, 1'b0, 1'b1, t0);
        tick();
        tick();
        tick();
        chk("sat_final", pc2, 3);
        chk("sat_fail",  fc2, 0);
        chk("sat_done",  done[2], 1);

        // Reset during WAIT of vector 2
        pulse_start(0, TT_NOR);
        send_vec(0, 1'b0, 1'b0, 1'b0, t0);
        tick();
        tick();
        tick();
        chk("pre_abort_pass", pc0, 1);
        send_vec(0, 1'b1, 1'b1, 1'b0, t0);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("abort_pass",  pc0, 0);
        chk("abort_busy",  busy[0], 0);
        chk("abort_ready", rdy[0], 0);
        chk("abort_dut",   {da[0], db[0]}, 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("abort_ff_valid", ffval[0], 0);
`endif
        // rst wins over start
        rst[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        start[0] = 1'b0;
        chk("rst_beats_start", busy[0], 0);

        // start in ACCEPT is ignored (truth stays NOR, counters kept)
        pulse_start(0, TT_NOR);
        send_vec(0, 1'b0, 1'b0, 1'b0, t0);
        tick();
        tick();
        tick();
        pulse_start(0, TT_AND);
        chk("ign_start_pass",  pc0, 1);
        chk("ign_start_ready", rdy[0], 1);
        send_vec(0, 1'b0, 1'b0, 1'b1, t0);
        tick();
        tick();
        tick();
        chk("ign_start_pass2", pc0, 2);
        chk("ign_start_fail",  fc0, 0);
        chk("ign_start_done",  done[0], 1);
        // start from DONE clears the counters
        pulse_start(0, TT_XOR);
        chk("done_start_pass", pc0, 0);
        chk("done_start_busy", busy[0], 1);
        chk("done_start_done", done[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
